// File: rtl/osecpu_core_mc_if.sv
// rtl/osecpu_core_mc_if.sv - instruction memory fetch port between core and imem
// The core drives the read strobe and address; imem returns the word MEM_LAT cycles later.
interface osecpu_core_mc_if #(
  parameter int PC_W = 16
);
  logic            imem_en;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_data;

  modport master (output imem_en, output imem_addr, input imem_data);
  modport slave  (input imem_en, input imem_addr, output imem_data);
endinterface

// File: rtl/osecpu_core_mc.sv
// rtl/osecpu_core_mc.sv - multi-cycle OSECPU integer core (fetch/wait/exec FSM)
// Wait-state instruction fetch, register-file ALU, JMP/CND flow control, HALT trap.
module osecpu_core_mc #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 16,
  parameter int REG_AW  = 6,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  osecpu_core_mc_if.master   imem,
  output logic [DATA_W-1:0]  dr,
  output logic [PC_W-1:0]    pc,
  output logic [7:0]         cr,
  output logic               halt
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_LIMM  = 8'h02;
  localparam logic [7:0] OP_JMP   = 8'h03;
  localparam logic [7:0] OP_CND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h10;
  localparam logic [7:0] OP_XOR   = 8'h11;
  localparam logic [7:0] OP_AND   = 8'h12;
  localparam logic [7:0] OP_ADD   = 8'h14;
  localparam logic [7:0] OP_SUB   = 8'h15;
  localparam logic [7:0] OP_CMPE  = 8'h20;
  localparam logic [7:0] OP_CMPNE = 8'h21;
  localparam logic [7:0] OP_CP    = 8'hD2;
  localparam logic [7:0] OP_CPDR  = 8'hD3;
  localparam logic [7:0] OP_END   = 8'hF0;

  state_t             state, next_state;
  logic [1:0]         cnt, cnt_d;
  logic [31:0]        instr, instr_d;
  logic               skip, skip_d;
  logic [PC_W-1:0]    pc_d;
  logic [DATA_W-1:0]  dr_d;
  logic [7:0]         cr_d;
  logic               reg_we;
  logic [DATA_W-1:0]  reg_wdata;

  logic [DATA_W-1:0]  regs [0:(1<<REG_AW)-1];

  logic [7:0]         op;
  logic [REG_AW-1:0]  ia, ib, ic;
  logic [15:0]        imm16;
  logic [DATA_W-1:0]  ra, rb, rc;

  assign op    = instr[31:24];
  assign ia    = instr[18 +: REG_AW];
  assign ib    = instr[12 +: REG_AW];
  assign ic    = instr[6 +: REG_AW];
  assign imm16 = instr[15:0];
  assign ra    = regs[ia];
  assign rb    = regs[ib];
  assign rc    = regs[ic];

  assign halt  = (state == HALT);

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state     = state;
    imem.imem_en   = 1'b0;
    imem.imem_addr = pc;
    cnt_d          = cnt;
    instr_d        = instr;
    skip_d         = skip;
    pc_d           = pc;
    dr_d           = dr;
    cr_d           = cr;
    reg_we         = 1'b0;
    reg_wdata      = '0;
    case (state)
      FETCH: begin
        // Strobe suppressed during reset so the pulse after reset is the first real fetch.
        imem.imem_en = !reset;
        cnt_d        = 2'(MEM_LAT - 1);
        next_state   = WAIT;
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          instr_d    = imem.imem_data;
          next_state = EXEC;
        end else begin
          cnt_d = cnt - 2'd1;
        end
      end
      EXEC: begin
        next_state = FETCH;
        pc_d       = pc + 1'b1;
        if (skip) begin
          skip_d = 1'b0;
        end else begin
          case (op)
            OP_NOP:   ;
            OP_LIMM:  begin reg_we = 1'b1; reg_wdata = {{(DATA_W-16){imm16[15]}}, imm16}; end
            OP_CP:    begin reg_we = 1'b1; reg_wdata = rb; end
            OP_OR:    begin reg_we = 1'b1; reg_wdata = rb | rc; end
            OP_XOR:   begin reg_we = 1'b1; reg_wdata = rb ^ rc; end
            OP_AND:   begin reg_we = 1'b1; reg_wdata = rb & rc; end
            OP_ADD:   begin reg_we = 1'b1; reg_wdata = rb + rc; end
            OP_SUB:   begin reg_we = 1'b1; reg_wdata = rb - rc; end
            OP_CMPE:  begin reg_we = 1'b1; reg_wdata = {DATA_W{rb == rc}}; end
            OP_CMPNE: begin reg_we = 1'b1; reg_wdata = {DATA_W{rb != rc}}; end
            OP_JMP:   pc_d = PC_W'(imm16);
            OP_CND:   skip_d = ~ra[0];
            OP_CPDR:  dr_d = ra;
            OP_END: begin
              cr_d       = 8'h01;
              pc_d       = pc;
              next_state = HALT;
            end
            default: begin
              cr_d       = 8'h02;
              pc_d       = pc;
              next_state = HALT;
            end
          endcase
        end
      end
      HALT: ;
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= '0;
      dr    <= '0;
      cr    <= 8'h00;
      cnt   <= 2'd0;
      skip  <= 1'b0;
      instr <= 32'h0;
    end else begin
      pc    <= pc_d;
      dr    <= dr_d;
      cr    <= cr_d;
      cnt   <= cnt_d;
      skip  <= skip_d;
      instr <= instr_d;
    end
  end

  // Register file is intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && reg_we) regs[ia] <= reg_wdata;
  end

endmodule

// File: tb/tb_osecpu_core_mc.sv
// tb/tb_osecpu_core_mc.sv - directed bench for osecpu_core_mc (MEM_LAT 1 and 3)
// Outside the data-valid cycle the imem models return DEADBEEF (an illegal opcode).
module tb_osecpu_core_mc;

  logic clk = 1'b0;
  logic rst0, rst3;
  always #5 clk = ~clk;

  osecpu_core_mc_if #(.PC_W(16)) bus0 ();
  osecpu_core_mc_if #(.PC_W(16)) bus3 ();

  logic [31:0] dr0, dr3;
  logic [15:0] pc0, pc3;
  logic [7:0]  cr0, cr3;
  logic        halt0, halt3;

  osecpu_core_mc #(.DATA_W(32), .PC_W(16), .REG_AW(6), .MEM_LAT(1)) dut0 (
    .clk(clk), .reset(rst0), .imem(bus0.master),
    .dr(dr0), .pc(pc0), .cr(cr0), .halt(halt0)
  );

  osecpu_core_mc #(.DATA_W(32), .PC_W(16), .REG_AW(6), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset(rst3), .imem(bus3.master),
    .dr(dr3), .pc(pc3), .cr(cr3), .halt(halt3)
  );

  logic [31:0] mem0 [0:255];
  logic [31:0] mem3 [0:255];

  logic        v0_q;
  logic [15:0] a0_q;
  logic [2:0]  v3_q;
  logic [15:0] a3_q [0:2];

  always_ff @(posedge clk) begin
    v0_q    <= bus0.imem_en;
    a0_q    <= bus0.imem_addr;
    v3_q    <= {v3_q[1:0], bus3.imem_en};
    a3_q[0] <= bus3.imem_addr;
    a3_q[1] <= a3_q[0];
    a3_q[2] <= a3_q[1];
  end

  assign bus0.imem_data = v0_q    ? mem0[a0_q[7:0]]    : 32'hDEADBEEF;
  assign bus3.imem_data = v3_q[2] ? mem3[a3_q[2][7:0]] : 32'hDEADBEEF;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_pc0(input logic [15:0] tgt);
    int n = 0;
    while (pc0 !== tgt && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_pc0", {48'h0, pc0}, {48'h0, tgt});
  endtask

  task automatic wait_halt0();
    int n = 0;
    while (halt0 !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_halt0", {63'h0, halt0}, 64'h1);
  endtask

  initial begin
    int n;
    int npos;
    int pos [0:3];

    for (int i = 0; i < 256; i++) begin
      mem0[i] = 32'h0;
      mem3[i] = 32'h0;
    end
    mem0[0]  = 32'h02040003;  // LIMM16 R1=3
    mem0[1]  = 32'h02080007;  // LIMM16 R2=7
    mem0[2]  = 32'h150C1080;  // SUB R3=R1-R2
    mem0[3]  = 32'hD30C0000;  // CPDR R3
    mem0[4]  = 32'h02048000;  // LIMM16 R1=8000h
    mem0[5]  = 32'hD3040000;  // CPDR R1
    mem0[6]  = 32'h14081040;  // ADD R2=R1+R1
    mem0[7]  = 32'hD3080000;  // CPDR R2
    mem0[8]  = 32'h20101040;  // CMPE R4=R1,R1
    mem0[9]  = 32'h04100000;  // CND R4
    mem0[10] = 32'h02140001;  // LIMM16 R5=1
    mem0[11] = 32'hD3140000;  // CPDR R5
    mem0[12] = 32'h21101040;  // CMPNE R4=R1,R1
    mem0[13] = 32'h04100000;  // CND R4 (R4=0)
    mem0[14] = 32'hF0000000;  // END, skipped
    mem0[15] = 32'hD3100000;  // CPDR R4
    mem0[16] = 32'h04100000;  // CND R4 -> skip next
    mem0[17] = 32'h04100000;  // CND R4, skipped, must not arm skip
    mem0[18] = 32'h02180055;  // LIMM16 R6=55h
    mem0[19] = 32'hD3180000;  // CPDR R6
    mem0[20] = 32'h03000020;  // JMP 0020h
    mem0[32] = 32'hF0000000;  // END

    rst0 = 1'b1;
    rst3 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pc",   {48'h0, pc0}, 64'h0);
    chk("rst_dr",   {32'h0, dr0}, 64'h0);
    chk("rst_cr",   {56'h0, cr0}, 64'h0);
    chk("rst_halt", {63'h0, halt0}, 64'h0);
    chk("rst_en",   {63'h0, bus0.imem_en}, 64'h0);

    rst0 = 1'b0;
    #1;
    chk("first_en",   {63'h0, bus0.imem_en}, 64'h1);
    chk("first_addr", {48'h0, bus0.imem_addr}, 64'h0);

    // CPI is 3 at MEM_LAT=1: four instructions take 12 cycles.
    @(negedge clk);
    n = 1;
    while (pc0 !== 16'd4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("cpi1_cycles", 64'(n), 64'd12);
    chk("sub_dr", {32'h0, dr0}, 64'hFFFFFFFC);

    wait_pc0(16'd6);
    chk("limm_sext", {32'h0, dr0}, 64'hFFFF8000);
    wait_pc0(16'd8);
    chk("add_carry", {32'h0, dr0}, 64'hFFFF0000);
    wait_pc0(16'd12);
    chk("cnd_taken", {32'h0, dr0}, 64'h1);
    wait_pc0(16'd16);
    chk("cmpne_dr",   {32'h0, dr0}, 64'h0);
    chk("skip_end_h", {63'h0, halt0}, 64'h0);
    chk("skip_end_c", {56'h0, cr0}, 64'h0);
    wait_pc0(16'd20);
    chk("cnd_cnd", {32'h0, dr0}, 64'h55);

    wait_halt0();
    chk("end_pc", {48'h0, pc0}, 64'h20);
    chk("end_cr", {56'h0, cr0}, 64'h01);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.imem_en === 1'b1) n++;
    end
    chk("halt_no_en", 64'(n), 64'd0);
    chk("halt_pc",    {48'h0, pc0}, 64'h20);
    chk("halt_dr",    {32'h0, dr0}, 64'h55);

    // Illegal opcode trap
    rst0 = 1'b1;
    mem0[0] = 32'h00000000;
    mem0[1] = 32'h00000000;
    mem0[2] = 32'h7F000000;
    @(negedge clk);
    rst0 = 1'b0;
    wait_halt0();
    chk("ill_cr", {56'h0, cr0}, 64'h02);
    chk("ill_pc", {48'h0, pc0}, 64'h2);
    repeat (4) @(negedge clk);
    chk("ill_hold_pc", {48'h0, pc0}, 64'h2);

    rst0 = 1'b1;
    @(negedge clk);
    #1;
    chk("rst2_pc",   {48'h0, pc0}, 64'h0);
    chk("rst2_cr",   {56'h0, cr0}, 64'h0);
    chk("rst2_halt", {63'h0, halt0}, 64'h0);
    rst0 = 1'b0;
    #1;
    chk("rst2_fetch", {63'h0, bus0.imem_en}, 64'h1);

    // MEM_LAT=3: fetch pulses every 5 cycles
    rst3 = 1'b0;
    #1;
    npos = 0;
    for (int c = 0; c < 16; c++) begin
      if (bus3.imem_en === 1'b1) begin
        if (npos < 4) pos[npos] = c;
        npos++;
      end
      @(negedge clk);
      #1;
    end
    chk("lat3_npulse", 64'(npos), 64'd4);
    chk("lat3_p0", 64'(pos[0]), 64'd0);
    chk("lat3_p1", 64'(pos[1]), 64'd5);
    chk("lat3_p2", 64'(pos[2]), 64'd10);
    chk("lat3_p3", 64'(pos[3]), 64'd15);
    chk("lat3_pc", {48'h0, pc3}, 64'h3);

    // Reset during WAIT restarts the fetch from address 0
    rst3 = 1'b1;
    @(negedge clk);
    #1;
    chk("lat3_rst_en", {63'h0, bus3.imem_en}, 64'h0);
    chk("lat3_rst_pc", {48'h0, pc3}, 64'h0);
    rst3 = 1'b0;
    #1;
    chk("lat3_re_en",   {63'h0, bus3.imem_en}, 64'h1);
    chk("lat3_re_addr", {48'h0, bus3.imem_addr}, 64'h0);
    repeat (5) @(negedge clk);
    #1;
    chk("lat3_next_en",   {63'h0, bus3.imem_en}, 64'h1);
    chk("lat3_next_addr", {48'h0, bus3.imem_addr}, 64'h1);
    chk("lat3_cr",        {56'h0, cr3}, 64'h0);
    chk("lat3_halt",      {63'h0, halt3}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
